// File: rtl/seven_seg_ntmux.sv
// seven_seg_ntmux: N-digit common-anode seven-segment multiplexer with dead-time blanking
module seven_seg_ntmux #(
  parameter int DIGITS = 4,
  parameter int P = 84,
  parameter int N = 24,
  parameter int DEAD_CYC = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [4*DIGITS-1:0]   digits,
  input  logic [DIGITS-1:0]     blank,
  input  logic [DIGITS-1:0]     dp,
  output logic [DIGITS-1:0]     pwr,
  output logic [6:0]            seg,
  output logic                  dp_n
);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  typedef enum logic {DEAD, DRIVE} state_t;
  state_t state, state_nx;
  logic [N-1:0] acc, acc_nx;
  logic tick;
  logic [7:0] cnt, cnt_nx;
  logic [IW-1:0] idx, idx_nx;
  logic on;
  logic [DIGITS-1:0] pwr_nx;
  logic [6:0] seg_nx;
  logic dp_n_nx;
  function automatic logic [6:0] seven_seg_dec(input logic [3:0] v);
    case (v)
      4'h0: return 7'h40;
      4'h1: return 7'h79;
      4'h2: return 7'h24;
      4'h3: return 7'h30;
      4'h4: return 7'h19;
      4'h5: return 7'h12;
      4'h6: return 7'h02;
      4'h7: return 7'h78;
      4'h8: return 7'h00;
      4'h9: return 7'h10;
      4'hA: return 7'h08;
      4'hB: return 7'h03;
      4'hC: return 7'h46;
      4'hD: return 7'h21;
      4'hE: return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction
  assign {tick, acc_nx} = {1'b0, acc} + (N+1)'(P);
  // next-state logic; outputs are derived from the next state so they register in step with it
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    idx_nx = idx;
    if (state == DEAD) begin
      cnt_nx = cnt + 8'd1;
      if (cnt == 8'(DEAD_CYC - 1)) begin
        state_nx = DRIVE;
        cnt_nx = '0;
      end
    end else if (tick) begin
      state_nx = DEAD;
      idx_nx = (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
    end
    on = state_nx == DRIVE && !blank[idx_nx];
    pwr_nx = on ? DIGITS'(1) << idx_nx : '0;
    seg_nx = on ? seven_seg_dec(digits[4*idx_nx +: 4]) : 7'h7F;
    dp_n_nx = on ? !dp[idx_nx] : 1'b1;
  end
  // state, phase accumulator and registered display drive
  always_ff @(posedge clk) begin
    if (!rstn) begin
      acc <= '0;
      state <= DEAD;
      cnt <= '0;
      idx <= '0;
      pwr <= '0;
      seg <= 7'h7F;
      dp_n <= 1'b1;
    end else begin
      acc <= acc_nx;
      state <= state_nx;
      cnt <= cnt_nx;
      idx <= idx_nx;
      pwr <= pwr_nx;
      seg <= seg_nx;
      dp_n <= dp_n_nx;
    end
  end
endmodule
